tcp_sched_flag_table: RTL and testbench
=======================================

Name: tcp_sched_flag_table

Overview:
- Per-flow pending-work scheduler for the TCP slow path.
- Accepts sched_cmd_struct commands (SET/CLEAR/NOP per flag) from the RX and timer engines and holds rt/ack/data flags plus timestamps for each flow.
- A round-robin scanner emits a sched_data_struct snapshot for each flow that has work; the TX packet-assembly engine consumes the snapshot.

Parameters:
- NUM_FLOWS, 16, number of table entries; flowids >= NUM_FLOWS are ignored. Must be ≥2 and ≤2**FLOWID_W.
- PTR_W, $clog2(NUM_FLOWS), width of the scan pointer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- sched_cmd_val  in  1  command valid.
- sched_cmd_data  in  SCHED_CMD_STRUCT_W  command: flowid plus three sched_flag_cmd_struct.
- sched_cmd_rdy  out  1  command accept.
- sched_out_val  out  1  snapshot valid.
- sched_out_data  out  SCHED_DATA_STRUCT_W  snapshot: flowid plus rt/ack_pend/data_pend sched_flag_data_struct.
- sched_out_rdy  in  1  consumer accept.
- sched_empty  out  1  registered; 1 when no flag is set in any entry.

Behaviour:
Reset (rst_n=0, async):
- All table flags and timestamps = 0, scan ptr = 0, state = SCAN.
- sched_out_val = 0, sched_out_data = 0, sched_empty = 1, sched_cmd_rdy = 0.

Command path:
- sched_cmd_rdy = 1 whenever out of reset. A command is accepted when val & rdy.
- Each of the three flag fields is applied independently to entry[flowid] at the accepting edge:
  - SET: flag <= 1, timestamp <= cmd timestamp. A SET on an already-set flag overwrites the timestamp.
  - CLEAR: flag <= 0, timestamp unchanged.
  - NOP, or encoding 2'b11: no change.
- flowid >= NUM_FLOWS: the command is accepted and discarded with no state change.
- sched_empty is recomputed from the post-update table and registered, so it reflects a command one cycle after acceptance.

Scanner FSM:
- SCAN:
  - Examine entry[ptr] using its registered (pre-command) value.
  - If any of the three flags is 1: capture {ptr, entry} into the sched_out_data register, go to OUTPUT, ptr held.
  - Otherwise: ptr <= (ptr == NUM_FLOWS-1) ? 0 : ptr+1.
  - Scan rate: one entry per cycle.
- OUTPUT:
  - sched_out_val = 1. sched_out_data is stable until the handshake.
  - On sched_out_rdy: ptr advances with wrap as above, then go to SCAN.
  - Commands accepted during OUTPUT update the table but not the held snapshot; the snapshot is not revoked even if its flags are cleared.
- Emission never modifies flags; the consumer clears flags via commands.
- Worst-case latency from a SET to the emission for that flow: NUM_FLOWS+1 cycles with no backpressure.

Simultaneous events:
- A command to entry[ptr] in the same cycle SCAN examines entry[ptr] is resolved as: the scan sees the old value, and the write lands.
- A flag newly set behind the pointer is found on the next lap.

Reset mid-OUTPUT:
- The snapshot is dropped, val = 0 immediately (async), and the table is cleared.

Widths:
- ptr is PTR_W wide.
- Output flowid = ptr zero-extended to FLOWID_W.

Decomposition:
- Keep sched_cmd_e, sched_flag_cmd_struct, sched_cmd_struct and sched_data_struct in tcp_misc_pkg (TIMESTAMP_W and FLOWID_W come from tcp_pkg).
- Add to tcp_misc_pkg:
  - sched_entry_struct: the three sched_flag_data_struct fields without flowid.
  - sched_fsm_e {SCAN, OUTPUT}.
- One natural sub-module, tcp_sched_flag_update: combinational apply of one sched_flag_cmd_struct to one sched_flag_data_struct, instantiated three times in the write path.

Test Plan:
1. Reset, then idle 40 cycles -> sched_out_val = 0, sched_empty = 1, sched_cmd_rdy = 1.
2. Command flowid=5, rt SET ts=0x100, others NOP; sched_out_rdy = 1 -> one emission {flowid=5, rt_flag={1,0x100}, ack/data flags 0} within NUM_FLOWS+1 cycles. sched_empty = 0 one cycle after acceptance. Emission repeats every lap until a CLEAR is sent.
3. SET data on flows 3 and 12, then hold sched_out_rdy = 0 for 10 cycles -> flow 3 snapshot held stable the whole time. After ready, the next emission is flow 12, then flow 3 again (round-robin wrap).
4. SET ack on flow 7, then CLEAR ack on flow 7 while the snapshot for 7 is in OUTPUT -> the held snapshot still shows ack=1. No further emission of 7; sched_empty returns to 1.
5. Command with flowid = NUM_FLOWS (16), rt SET -> accepted, no emission, sched_empty stays 1.
6. Assert rst_n = 0 while sched_out_val = 1 -> sched_out_val drops without a clock edge. After release, no emissions until new SETs arrive.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// Slow-path scheduler types: flag commands, per-flow entries and snapshots.
package tcp_misc_pkg;
  import tcp_pkg::*;

  // Per-flag command; encoding 2'b11 is unused and treated as no change.
  typedef enum logic [1:0] {
    SCHED_NOP   = 2'b00,
    SCHED_SET   = 2'b01,
    SCHED_CLEAR = 2'b10
  } sched_cmd_e;

  typedef struct packed {
    sched_cmd_e             cmd;
    logic [TIMESTAMP_W-1:0] timestamp;
  } sched_flag_cmd_struct;

  typedef struct packed {
    logic                   flag;
    logic [TIMESTAMP_W-1:0] timestamp;
  } sched_flag_data_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]  flowid;
    sched_flag_cmd_struct rt;
    sched_flag_cmd_struct ack_pend;
    sched_flag_cmd_struct data_pend;
  } sched_cmd_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]   flowid;
    sched_flag_data_struct rt;
    sched_flag_data_struct ack_pend;
    sched_flag_data_struct data_pend;
  } sched_data_struct;

  // One table entry: the snapshot without its flowid.
  typedef struct packed {
    sched_flag_data_struct rt;
    sched_flag_data_struct ack_pend;
    sched_flag_data_struct data_pend;
  } sched_entry_struct;

  typedef enum logic {
    SCAN   = 1'b0,
    OUTPUT = 1'b1
  } sched_fsm_e;

  localparam int SCHED_CMD_STRUCT_W  = $bits(sched_cmd_struct);
  localparam int SCHED_DATA_STRUCT_W = $bits(sched_data_struct);

  // An entry has pending work when any of its three flags is set.
  function automatic logic entry_has_work(input sched_entry_struct e);
    return e.rt.flag | e.ack_pend.flag | e.data_pend.flag;
  endfunction

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP engine widths.
package tcp_pkg;

  localparam int TIMESTAMP_W = 32;
  localparam int FLOWID_W    = 8;

endpackage

// File: rtl/tcp_sched_flag_update.sv
// Applies one flag command to one flag/timestamp pair (purely combinational).
module tcp_sched_flag_update
  import tcp_misc_pkg::*;
(
  input  sched_flag_cmd_struct  cmd,
  input  sched_flag_data_struct cur,
  output sched_flag_data_struct nxt
);

  // SET overwrites the timestamp, CLEAR keeps it, anything else holds.
  always_comb begin
    nxt = cur;
    case (cmd.cmd)
      SCHED_SET: begin
        nxt.flag      = 1'b1;
        nxt.timestamp = cmd.timestamp;
      end
      SCHED_CLEAR: nxt.flag = 1'b0;
      default:     nxt = cur;
    endcase
  end

endmodule

// File: rtl/tcp_sched_flag_table.sv
// Per-flow pending-work table with a round-robin scanner that hands one
// flow snapshot at a time to the TX assembly engine.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. sched_out_val, once raised, stays high with
// sched_out_data unchanged until that transfer; it never depends on
// sched_out_rdy. sched_cmd_rdy is high whenever out of reset.
module tcp_sched_flag_table
  import tcp_pkg::*;
  import tcp_misc_pkg::*;
#(
  parameter int NUM_FLOWS = 16,
  parameter int PTR_W     = $clog2(NUM_FLOWS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sched_cmd_val,
  input  logic [SCHED_CMD_STRUCT_W-1:0]  sched_cmd_data,
  output logic                           sched_cmd_rdy,
  output logic                           sched_out_val,
  output logic [SCHED_DATA_STRUCT_W-1:0] sched_out_data,
  input  logic                           sched_out_rdy,
  output logic                           sched_empty
);

  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(NUM_FLOWS - 1);
  localparam logic [FLOWID_W:0] FLOW_LIMIT  = (FLOWID_W + 1)'(NUM_FLOWS);

  sched_entry_struct     table_q [NUM_FLOWS];
  sched_entry_struct     table_d [NUM_FLOWS];
  sched_cmd_struct       cmd;
  sched_entry_struct     cur_entry;
  sched_entry_struct     scan_entry;
  sched_flag_data_struct rt_nxt, ack_nxt, data_nxt;
  sched_data_struct      out_q;
  sched_fsm_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d, ptr_next;
  logic [PTR_W-1:0]      cmd_idx;
  logic                  cmd_rdy_q;
  logic                  cmd_fire;
  logic                  cmd_in_range;
  logic                  capture;
  logic                  empty_q, empty_d;

  assign cmd           = sched_cmd_struct'(sched_cmd_data);
  assign cmd_fire      = sched_cmd_val & cmd_rdy_q;
  assign cmd_in_range  = ({1'b0, cmd.flowid} < FLOW_LIMIT);
  assign cmd_idx       = cmd.flowid[PTR_W-1:0];
  assign cur_entry     = table_q[cmd_idx];
  assign scan_entry    = table_q[ptr_q];
  assign ptr_next      = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

  assign sched_cmd_rdy  = cmd_rdy_q;
  assign sched_out_val  = (state_q == OUTPUT);
  assign sched_out_data = out_q;
  assign sched_empty    = empty_q;

  tcp_sched_flag_update u_upd_rt (
    .cmd (cmd.rt),
    .cur (cur_entry.rt),
    .nxt (rt_nxt)
  );

  tcp_sched_flag_update u_upd_ack (
    .cmd (cmd.ack_pend),
    .cur (cur_entry.ack_pend),
    .nxt (ack_nxt)
  );

  tcp_sched_flag_update u_upd_data (
    .cmd (cmd.data_pend),
    .cur (cur_entry.data_pend),
    .nxt (data_nxt)
  );

  // Next table: accepted, in-range commands rewrite the addressed entry.
  always_comb begin
    table_d = table_q;
    if (cmd_fire && cmd_in_range) begin
      table_d[cmd_idx].rt        = rt_nxt;
      table_d[cmd_idx].ack_pend  = ack_nxt;
      table_d[cmd_idx].data_pend = data_nxt;
    end
  end

  // Emptiness of the post-update table, registered alongside it.
  always_comb begin
    empty_d = 1'b1;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      if (entry_has_work(table_d[i])) empty_d = 1'b0;
    end
  end

  // Table storage, command-ready and empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FLOWS; i++) table_q[i] <= '0;
      cmd_rdy_q <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      table_q   <= table_d;
      cmd_rdy_q <= 1'b1;
      empty_q   <= empty_d;
    end
  end

  // Scanner next state: SCAN looks at the registered entry under the
  // pointer (a same-cycle command is not visible yet), OUTPUT holds until
  // the consumer takes the snapshot.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    capture = 1'b0;
    case (state_q)
      SCAN: begin
        if (entry_has_work(scan_entry)) begin
          capture = 1'b1;
          state_d = OUTPUT;
        end else begin
          ptr_d = ptr_next;
        end
      end
      OUTPUT: begin
        if (sched_out_rdy) begin
          ptr_d   = ptr_next;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Scanner state, pointer and held snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (capture) begin
        out_q.flowid    <= FLOWID_W'(ptr_q);
        out_q.rt        <= scan_entry.rt;
        out_q.ack_pend  <= scan_entry.ack_pend;
        out_q.data_pend <= scan_entry.data_pend;
      end
    end
  end

endmodule

// File: tb/tb_tcp_sched_flag_table.sv
// Directed bench for the slow-path flag table and its round-robin scanner.
module tb_tcp_sched_flag_table;
  import tcp_pkg::*;
  import tcp_misc_pkg::*;

  localparam int NUM_FLOWS = 16;
  localparam int BUDGET    = 2 * NUM_FLOWS + 4;
  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_SET = 2'b01;
  localparam logic [1:0] C_CLR = 2'b10;
  localparam logic [1:0] C_BAD = 2'b11;

  logic                           clk;
  logic                           rst_n;
  logic                           sched_cmd_val;
  logic [SCHED_CMD_STRUCT_W-1:0]  sched_cmd_data;
  logic                           sched_cmd_rdy;
  logic                           sched_out_val;
  logic [SCHED_DATA_STRUCT_W-1:0] sched_out_data;
  logic                           sched_out_rdy;
  logic                           sched_empty;

  int total;
  int bad;
  logic [SCHED_DATA_STRUCT_W-1:0] exp_q[$];

  tcp_sched_flag_table #(.NUM_FLOWS(NUM_FLOWS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sched_cmd_val  (sched_cmd_val),
    .sched_cmd_data (sched_cmd_data),
    .sched_cmd_rdy  (sched_cmd_rdy),
    .sched_out_val  (sched_out_val),
    .sched_out_data (sched_out_data),
    .sched_out_rdy  (sched_out_rdy),
    .sched_empty    (sched_empty)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SCHED_DATA_STRUCT_W-1:0] mk_snap(
      input logic [FLOWID_W-1:0] f, input int which, input logic [TIMESTAMP_W-1:0] ts);
    sched_data_struct s;
    s = '0;
    s.flowid = f;
    case (which)
      0:       begin s.rt.flag = 1'b1;        s.rt.timestamp = ts;        end
      1:       begin s.ack_pend.flag = 1'b1;  s.ack_pend.timestamp = ts;  end
      default: begin s.data_pend.flag = 1'b1; s.data_pend.timestamp = ts; end
    endcase
    return s;
  endfunction

  // Drive one command for exactly one accepting edge.
  task automatic send_cmd(input logic [FLOWID_W-1:0] f,
                          input logic [1:0] rc, input logic [TIMESTAMP_W-1:0] rts,
                          input logic [1:0] ac, input logic [TIMESTAMP_W-1:0] ats,
                          input logic [1:0] dc, input logic [TIMESTAMP_W-1:0] dts);
    sched_cmd_struct c;
    c.flowid              = f;
    c.rt.cmd              = sched_cmd_e'(rc);
    c.rt.timestamp        = rts;
    c.ack_pend.cmd        = sched_cmd_e'(ac);
    c.ack_pend.timestamp  = ats;
    c.data_pend.cmd       = sched_cmd_e'(dc);
    c.data_pend.timestamp = dts;
    sched_cmd_data = c;
    sched_cmd_val  = 1'b1;
    tick();
    sched_cmd_val  = 1'b0;
    sched_cmd_data = '0;
  endtask

  // Wait (bounded) for the next cycle with a valid snapshot; compare with exp_q head.
  task automatic wait_emit(input string tag);
    logic seen;
    logic [SCHED_DATA_STRUCT_W-1:0] exp;
    seen = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (sched_out_val) begin
        seen = 1'b1;
        break;
      end
    end
    exp = exp_q.pop_front();
    check({tag, "_val"}, 128'(seen), 128'(1'b1));
    if (seen) check({tag, "_data"}, 128'(sched_out_data), 128'(exp));
  endtask

  task automatic count_val(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sched_out_val) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int unstable;
    logic [SCHED_DATA_STRUCT_W-1:0] held;
    total = 0;
    bad   = 0;
    rst_n          = 1'b0;
    sched_cmd_val  = 1'b0;
    sched_cmd_data = '0;
    sched_out_rdy  = 1'b1;

    // 1: reset values, then idle
    repeat (3) tick();
    check("rst_val",   128'(sched_out_val),  128'(1'b0));
    check("rst_data",  128'(sched_out_data), 128'(0));
    check("rst_empty", 128'(sched_empty),    128'(1'b1));
    check("rst_rdy",   128'(sched_cmd_rdy),  128'(1'b0));
    rst_n = 1'b1;
    count_val(40, cnt);
    check("idle_emits", 128'(cnt), 128'(0));
    check("idle_empty", 128'(sched_empty), 128'(1'b1));
    check("idle_rdy",   128'(sched_cmd_rdy), 128'(1'b1));

    // 2: single rt SET on flow 5, repeats every lap until cleared
    send_cmd(8'd5, C_SET, 32'h100, C_NOP, 32'h0, C_NOP, 32'h0);
    check("t2_empty_after_set", 128'(sched_empty), 128'(1'b0));
    exp_q.push_back(mk_snap(8'd5, 0, 32'h100));
    wait_emit("t2_first");
    exp_q.push_back(mk_snap(8'd5, 0, 32'h100));
    wait_emit("t2_lap");
    send_cmd(8'd5, C_CLR, 32'h0, C_NOP, 32'h0, C_NOP, 32'h0);
    check("t2_empty_after_clr", 128'(sched_empty), 128'(1'b1));
    count_val(40, cnt);
    check("t2_no_emit", 128'(cnt), 128'(0));

    // 3: backpressure on flow 3, then round-robin 12 -> 3
    sched_out_rdy = 1'b0;
    send_cmd(8'd3, C_NOP, 32'h0, C_NOP, 32'h0, C_SET, 32'h33);
    exp_q.push_back(mk_snap(8'd3, 2, 32'h33));
    wait_emit("t3_hold_first");
    send_cmd(8'd12, C_NOP, 32'h0, C_NOP, 32'h0, C_SET, 32'hC0);
    send_cmd(8'd3,  C_NOP, 32'h0, C_NOP, 32'h0, C_SET, 32'h34);
    held = mk_snap(8'd3, 2, 32'h33);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!sched_out_val || sched_out_data !== held) unstable++;
    end
    check("t3_stable_cycles", 128'(unstable), 128'(0));
    check("t3_held_data", 128'(sched_out_data), 128'(held));
    sched_out_rdy = 1'b1;
    exp_q.push_back(mk_snap(8'd12, 2, 32'hC0));
    wait_emit("t3_flow12");
    exp_q.push_back(mk_snap(8'd3, 2, 32'h34));
    wait_emit("t3_flow3_wrap");
    send_cmd(8'd3,  C_NOP, 32'h0, C_NOP, 32'h0, C_CLR, 32'h0);
    send_cmd(8'd12, C_NOP, 32'h0, C_NOP, 32'h0, C_CLR, 32'h0);
    check("t3_empty", 128'(sched_empty), 128'(1'b1));

    // 4: CLEAR while the snapshot is held does not revoke it
    sched_out_rdy = 1'b0;
    send_cmd(8'd7, C_NOP, 32'h0, C_SET, 32'h77, C_NOP, 32'h0);
    exp_q.push_back(mk_snap(8'd7, 1, 32'h77));
    wait_emit("t4_emit");
    send_cmd(8'd7, C_NOP, 32'h0, C_CLR, 32'h0, C_NOP, 32'h0);
    check("t4_val_held",  128'(sched_out_val),  128'(1'b1));
    check("t4_data_held", 128'(sched_out_data), 128'(mk_snap(8'd7, 1, 32'h77)));
    check("t4_empty",     128'(sched_empty),    128'(1'b1));
    sched_out_rdy = 1'b1;
    tick();
    count_val(40, cnt);
    check("t4_no_reemit", 128'(cnt), 128'(0));

    // 5: out-of-range flowid is accepted and discarded
    send_cmd(8'd16, C_SET, 32'h55, C_SET, 32'h55, C_SET, 32'h55);
    check("t5_empty_now", 128'(sched_empty), 128'(1'b1));
    count_val(40, cnt);
    check("t5_no_emit", 128'(cnt), 128'(0));
    check("t5_empty_later", 128'(sched_empty), 128'(1'b1));

    // 6: asynchronous reset while a snapshot is held
    sched_out_rdy = 1'b0;
    send_cmd(8'd9, C_SET, 32'h99, C_NOP, 32'h0, C_NOP, 32'h0);
    exp_q.push_back(mk_snap(8'd9, 0, 32'h99));
    wait_emit("t6_emit");
    #2 rst_n = 1'b0;
    #1;
    check("t6_val_async",   128'(sched_out_val),  128'(1'b0));
    check("t6_data_async",  128'(sched_out_data), 128'(0));
    check("t6_empty_async", 128'(sched_empty),    128'(1'b1));
    check("t6_rdy_async",   128'(sched_cmd_rdy),  128'(1'b0));
    repeat (2) tick();
    rst_n = 1'b1;
    sched_out_rdy = 1'b1;
    count_val(40, cnt);
    check("t6_no_emit", 128'(cnt), 128'(0));
    check("t6_rdy_back", 128'(sched_cmd_rdy), 128'(1'b1));

    // Unused encoding 2'b11 changes nothing
    send_cmd(8'd2, C_BAD, 32'hAA, C_BAD, 32'hAA, C_BAD, 32'hAA);
    check("enc11_empty", 128'(sched_empty), 128'(1'b1));
    count_val(40, cnt);
    check("enc11_no_emit", 128'(cnt), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
